// File: rtl/begin_line_pkg.sv
// Shared types and constants for the start-screen controller (begin_line).
package begin_line_pkg;

  typedef logic [2:0] level_t;

  typedef enum logic {
    ST_IDLE,
    ST_PASS
  } bl_state_t;

  localparam logic [7:0] KEY_ENTER = 8'h0D;
  localparam logic [7:0] KEY_1     = 8'h31;
  localparam logic [7:0] KEY_2     = 8'h32;
  localparam logic [7:0] KEY_3     = 8'h33;
  localparam logic [7:0] KEY_4     = 8'h34;
  localparam logic [7:0] KEY_5     = 8'h35;
  localparam logic [7:0] KEY_W     = 8'h77;
  localparam logic [7:0] KEY_W_UC  = 8'h57;
  localparam logic [7:0] KEY_S     = 8'h73;
  localparam logic [7:0] KEY_S_UC  = 8'h53;

  localparam int DEF_MARK_X0     = 200;
  localparam int DEF_MARK_W      = 16;
  localparam int DEF_MARK_Y0     = 192;
  localparam int DEF_MARK_PITCH  = 32;
  localparam int DEF_MARK_H      = 16;
  localparam int DEF_NUM_LEVELS  = 5;

endpackage

// File: rtl/begin_line_mask.sv
// Row mask that toggles the old marker band off and the new one on in one XOR.
module begin_line_mask
  import begin_line_pkg::*;
#(
  parameter int MARK_Y0    = DEF_MARK_Y0,
  parameter int MARK_PITCH = DEF_MARK_PITCH,
  parameter int MARK_H     = DEF_MARK_H
) (
  input  level_t       shown,
  input  level_t       target,
  output logic [0:479] mask
);

  // Level 0 means "nothing drawn", so its band is empty.
  function automatic logic in_band(input level_t l, input int r);
    int lo;
    if (l == 3'd0) return 1'b0;
    lo = MARK_Y0 + (int'(l) - 1) * MARK_PITCH;
    return (r >= lo) && (r < lo + MARK_H);
  endfunction

  always_comb begin
    mask = '0;
    for (int r = 0; r < 480; r++)
      mask[r] = in_band(shown, r) ^ in_band(target, r);
  end

endmodule

// File: rtl/begin_line.sv
// Start-screen level selector: draws the selection marker by RMW of column words.
// Optional BEGIN_LINE_KEYNAV_EN adds w/s step navigation.
module begin_line
  import begin_line_pkg::*;
#(
  parameter int MARK_X0    = DEF_MARK_X0,
  parameter int MARK_W     = DEF_MARK_W,
  parameter int MARK_Y0    = DEF_MARK_Y0,
  parameter int MARK_PITCH = DEF_MARK_PITCH,
  parameter int MARK_H     = DEF_MARK_H,
  parameter int NUM_LEVELS = DEF_NUM_LEVELS
) (
  input  logic         clk,
  input  logic         clk_rst,
  input  logic [9:0]   h_addr,
  input  logic [0:479] DisLine,
  input  logic [7:0]   Ascii,
  input  logic         clra,
  output logic [0:479] FallLine,
  output logic [9:0]   w_addr,
  output logic         ready,
  output logic         start,
  output logic [2:0]   level,
  output logic         led0
);

  localparam logic [9:0] X_LO    = 10'(MARK_X0);
  localparam logic [9:0] X_HI    = 10'(MARK_X0 + MARK_W);
  localparam level_t     MAX_LVL = level_t'(NUM_LEVELS);

  bl_state_t    state;
  level_t       shown, target, lvl_nxt;
  logic         busy;
  logic [9:0]   h_q, last_col;
  logic [0:479] mask;

  begin_line_mask #(
    .MARK_Y0   (MARK_Y0),
    .MARK_PITCH(MARK_PITCH),
    .MARK_H    (MARK_H)
  ) u_mask (
    .shown (shown),
    .target(target),
    .mask  (mask)
  );

  // Digit codes 0x31..0x35 carry the level in their low three bits.
  always_comb begin
    lvl_nxt = level;
    if (Ascii >= KEY_1 && Ascii <= KEY_5 && Ascii[2:0] <= MAX_LVL)
      lvl_nxt = Ascii[2:0];
`ifdef BEGIN_LINE_KEYNAV_EN
    else if ((Ascii == KEY_W || Ascii == KEY_W_UC) && level > 3'd1)
      lvl_nxt = level - 3'd1;
    else if ((Ascii == KEY_S || Ascii == KEY_S_UC) && level < MAX_LVL)
      lvl_nxt = level + 3'd1;
`endif
  end

  assign led0 = start;

  always_ff @(posedge clk or negedge clk_rst) begin
    if (!clk_rst) begin
      state    <= ST_IDLE;
      start    <= 1'b0;
      level    <= 3'd1;
      ready    <= 1'b0;
      w_addr   <= '0;
      FallLine <= '0;
      shown    <= 3'd0;
      target   <= 3'd0;
      busy     <= 1'b0;
      h_q      <= '0;
      last_col <= '1;
    end else begin
      ready <= 1'b0;
      h_q   <= h_addr;
      if (clra && !start) begin
        level <= lvl_nxt;
        if (Ascii == KEY_ENTER && !busy && shown == level)
          start <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (!start && shown != level && h_addr < X_LO) begin
            target <= level;
            busy   <= 1'b1;
            state  <= ST_PASS;
          end
        end
        ST_PASS: begin
          // DisLine is the word for h_q (one-cycle RAM latency).
          if (h_q >= X_LO && h_q < X_HI && h_q != last_col) begin
            ready    <= 1'b1;
            w_addr   <= h_q;
            FallLine <= DisLine ^ mask;
            last_col <= h_q;
          end
          if (h_q >= X_HI) begin
            shown    <= target;
            busy     <= 1'b0;
            last_col <= '1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_begin_line.sv
// Directed bench for begin_line with a behavioural column RAM model.
module tb_begin_line;

  logic         clk = 1'b0;
  logic         clk_rst;
  logic [9:0]   h_addr;
  logic [0:479] DisLine;
  logic [7:0]   Ascii;
  logic         clra;
  logic [0:479] FallLine;
  logic [9:0]   w_addr;
  logic         ready, start, led0;
  logic [2:0]   level;

  logic [0:479] ram [0:1023] = '{default: '0};
  int           wcnt [0:1023] = '{default: 0};
  int           wtotal = 0;
  int           base [0:1023];
  int           base_total;
  int           errors = 0;
  int           checks = 0;

  begin_line dut (
    .clk(clk), .clk_rst(clk_rst), .h_addr(h_addr), .DisLine(DisLine),
    .Ascii(Ascii), .clra(clra), .FallLine(FallLine), .w_addr(w_addr),
    .ready(ready), .start(start), .level(level), .led0(led0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    DisLine <= ram[h_addr];
    if (ready) begin
      ram[w_addr]  <= FallLine;
      wcnt[w_addr] <= wcnt[w_addr] + 1;
      wtotal       <= wtotal + 1;
    end
  end

  task automatic chk(input string tag, input logic [479:0] obs, input logic [479:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:479] rows(input int lo);
    logic [0:479] v;
    v = '0;
    for (int r = lo; r < lo + 16; r++) v[r] = 1'b1;
    return v;
  endfunction

  task automatic snap();
    base_total = wtotal;
    for (int i = 0; i < 1024; i++) base[i] = wcnt[i];
  endtask

  function automatic int pass_writes();
    return wtotal - base_total;
  endfunction

  function automatic int pass_max();
    int m;
    m = 0;
    for (int i = 0; i < 1024; i++)
      if (wcnt[i] - base[i] > m) m = wcnt[i] - base[i];
    return m;
  endfunction

  task automatic sweep(input int lo, input int hi);
    for (int h = lo; h <= hi; h++) begin
      @(negedge clk);
      h_addr = 10'(h);
    end
  endtask

  task automatic park();
    @(negedge clk);
    h_addr = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic key(input logic [7:0] k);
    @(negedge clk);
    Ascii = k;
    clra  = 1'b1;
    @(negedge clk);
    clra  = 1'b0;
  endtask

  initial begin
    clk_rst = 1'b0;
    h_addr  = '0;
    Ascii   = '0;
    clra    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_level", level, 1);
    chk("rst_ready", ready, 0);
    chk("rst_waddr", w_addr, 0);
    chk("rst_fall", FallLine, 0);
    chk("rst_led0", led0, 0);

    // First pass draws level 1 on an all-zero bitmap.
    snap();
    clk_rst = 1'b1;
    sweep(0, 639);
    park();
    chk("t1_writes", pass_writes(), 16);
    chk("t1_once", pass_max(), 1);
    chk("t1_col200", ram[200], rows(192));
    chk("t1_col207", ram[207], rows(192));
    chk("t1_col215", ram[215], rows(192));
    chk("t1_col199", ram[199], 0);
    chk("t1_col216", ram[216], 0);
    snap();
    sweep(0, 639);
    park();
    chk("t1_no_repass", pass_writes(), 0);

    // Move to level 3.
    snap();
    key(8'h33);
    chk("t2_level", level, 3);
    sweep(0, 639);
    park();
    chk("t2_writes", pass_writes(), 16);
    chk("t2_col200", ram[200], rows(256));
    chk("t2_col215", ram[215], rows(256));

    // Level 2, then '3' and Enter mid-pass with h_addr parked on column 205.
    snap();
    key(8'h32);
    sweep(0, 205);
    key(8'h33);
    key(8'h0D);
    chk("t3_enter_busy", start, 0);
    chk("t3_level", level, 3);
    sweep(206, 639);
    park();
    chk("t3_writes", pass_writes(), 16);
    chk("t3_once", pass_max(), 1);
    chk("t3_col205", ram[205], rows(224));
    snap();
    key(8'h0D);
    chk("t3_enter_stale", start, 0);
    sweep(0, 639);
    park();
    chk("t3_followup", pass_writes(), 16);
    chk("t3_col200", ram[200], rows(256));

    // Ignored codes.
    snap();
    key(8'h39);
    key(8'h78);
    key(8'h36);
    chk("t5_level", level, 3);
    sweep(0, 639);
    park();
    chk("t5_no_pass", pass_writes(), 0);

    key(8'h77);
`ifdef BEGIN_LINE_KEYNAV_EN
    chk("kn_w", level, 2);
`else
    chk("kn_w", level, 3);
`endif
    key(8'h73);
    chk("kn_s", level, 3);
    sweep(0, 639);
    park();
    sweep(0, 639);
    park();

    key(8'h0D);
    chk("t3_start", start, 1);
    chk("t3_led0", led0, 1);
    chk("t3_level_final", level, 3);

    // After start, keys and passes are locked out.
    snap();
    key(8'h32);
    chk("t4_level", level, 3);
    sweep(0, 639);
    park();
    chk("t4_no_write", pass_writes(), 0);
    chk("t4_start", start, 1);

    // Reset in the middle of a pass.
    @(negedge clk);
    clk_rst = 1'b0;
    @(negedge clk);
    clk_rst = 1'b1;
    chk("t6_level_rst", level, 1);
    sweep(0, 205);
    @(negedge clk);
    chk("t6_pre_ready", ready, 1);
    chk("t6_pre_waddr", w_addr, 204);
    clk_rst = 1'b0;
    #1;
    chk("t6_ready", ready, 0);
    chk("t6_start", start, 0);
    chk("t6_level", level, 1);
    chk("t6_waddr", w_addr, 0);
    chk("t6_fall", FallLine, 0);
    chk("t6_led0", led0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
